// File: rtl/cmd_frame_tx.sv
// ---------------------------------------------------------------------------
// cmd_frame_tx
//   Serial command-frame transmitter. Accepts one command set (mode, speed,
//   direction) through a valid/ready handshake and sends it on an idle-high
//   line in this order: start(0), mode[1:0], speed_cmd MSB first, dir_cmd MSB
//   first, even parity, stop(1). An idle gap of gap_bits bit-times follows the
//   stop bit. Each line bit lasts bit_div clock cycles.
//
// Parameters
//   cmd_l     width of speed_cmd and dir_cmd
//   bit_div   clock cycles per line bit (>= 1)
//   gap_bits  idle bit-times after the stop bit (0 allowed)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   valid      command set present on speed_cmd / dir_cmd / mode
//   speed_cmd  speed command to send
//   dir_cmd    direction command to send
//   mode       operation mode to send
//   ready      block can accept a frame
//   tx         serial line, idle high (registered)
//   busy       frame or gap in progress (always ~ready)
//   frame_cnt  completed frames, wraps at 256
// ---------------------------------------------------------------------------
module cmd_frame_tx #(
  parameter int cmd_l    = 4,
  parameter int bit_div  = 8,
  parameter int gap_bits = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [cmd_l-1:0] speed_cmd,
  input  logic [cmd_l-1:0] dir_cmd,
  input  logic [1:0]       mode,
  output logic             ready,
  output logic             tx,
  output logic             busy,
  output logic [7:0]       frame_cnt
);

  // Payload bits between start bit and parity bit.
  localparam int P  = 2 * cmd_l + 2;
  // Bit-timer width; at least one bit even when bit_div = 1.
  localparam int TW = (bit_div > 1) ? $clog2(bit_div) : 1;
  // Bit counter covers both payload positions and gap bit-times.
  localparam int CW = $clog2(P + gap_bits + 1);

  localparam logic [TW-1:0] BIT_LAST  = TW'(bit_div - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(P - 1);
  localparam logic [CW-1:0] GAP_LAST  = (gap_bits > 0) ? CW'(gap_bits - 1) : '0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    GAP
  } state_t;

  state_t          state;
  logic [TW-1:0]   bit_timer;
  logic [CW-1:0]   bit_cnt;
  logic [P-1:0]    shift_reg;
  logic            parity;

  logic            bit_end;
  logic            frame_last;
  logic            accept;
  logic [P-1:0]    payload;

  assign payload = {mode, speed_cmd, dir_cmd};
  assign bit_end = (bit_timer == BIT_LAST);

  // Last cycle of the final bit-time of a frame (stop bit when there is no
  // gap, otherwise the last gap bit). The block is ready from the edge that
  // ends this cycle, so a valid present at that edge is taken as the accept of
  // the first ready cycle; this gives back-to-back frames with no idle cycle.
  assign frame_last = bit_end &&
                      ((gap_bits == 0) ? (state == STOP)
                                       : (state == GAP && bit_cnt == GAP_LAST));

  assign accept = valid && (ready || frame_last);

  assign busy = ~ready;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of the others; blocking here would make the
  // result depend on statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      ready     <= 1'b1;
      frame_cnt <= '0;
      bit_timer <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      parity    <= 1'b0;
    end else begin
      // Completed stop bit: count it, whether or not a frame chains behind it.
      if (state == STOP && bit_end) begin
        frame_cnt <= frame_cnt + 8'd1;
      end

      // Bit timer runs only while a frame or gap is in progress.
      bit_timer <= (state == IDLE || bit_end) ? '0 : bit_timer + TW'(1);

      if (accept) begin
        shift_reg <= payload;
        parity    <= ^payload;
        bit_cnt   <= '0;
        tx        <= 1'b0;
        ready     <= 1'b0;
        state     <= START;
      end else if (bit_end) begin
        case (state)
          START: begin
            state     <= DATA;
            tx        <= shift_reg[P-1];
            shift_reg <= {shift_reg[P-2:0], 1'b0};
            bit_cnt   <= '0;
          end
          DATA: begin
            if (bit_cnt == DATA_LAST) begin
              state <= PARITY;
              tx    <= parity;
            end else begin
              bit_cnt   <= bit_cnt + CW'(1);
              tx        <= shift_reg[P-1];
              shift_reg <= {shift_reg[P-2:0], 1'b0};
            end
          end
          PARITY: begin
            state <= STOP;
            tx    <= 1'b1;
          end
          STOP: begin
            if (gap_bits == 0) begin
              state <= IDLE;
              ready <= 1'b1;
            end else begin
              state   <= GAP;
              bit_cnt <= '0;
            end
          end
          GAP: begin
            if (bit_cnt == GAP_LAST) begin
              state <= IDLE;
              ready <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_cmd_frame_tx
//   Directed bench for cmd_frame_tx. Instance a: cmd_l=4, bit_div=4,
//   gap_bits=2 (frame period 60 cycles). Instance b: cmd_l=4, bit_div=1,
//   gap_bits=0 (frame period 13 cycles). Outputs are sampled on the falling
//   clock edge; "cycle c" is the clock period that begins at rising edge c,
//   with edge 0 the accept edge.
// ---------------------------------------------------------------------------
module tb_cmd_frame_tx;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic       valid_a, valid_b;
  logic [1:0] mode_a, mode_b;
  logic [3:0] speed_a, dir_a, speed_b, dir_b;
  logic       ready_a, tx_a, busy_a;
  logic       ready_b, tx_b, busy_b;
  logic [7:0] cnt_a, cnt_b;

  int n_vec    = 0;
  int n_miss   = 0;
  int exp_cnt_a = 0;

  cmd_frame_tx #(.cmd_l(4), .bit_div(4), .gap_bits(2)) u_a (
    .clk       (clk),
    .rst       (rst_a),
    .valid     (valid_a),
    .speed_cmd (speed_a),
    .dir_cmd   (dir_a),
    .mode      (mode_a),
    .ready     (ready_a),
    .tx        (tx_a),
    .busy      (busy_a),
    .frame_cnt (cnt_a)
  );

  cmd_frame_tx #(.cmd_l(4), .bit_div(1), .gap_bits(0)) u_b (
    .clk       (clk),
    .rst       (rst_b),
    .valid     (valid_b),
    .speed_cmd (speed_b),
    .dir_cmd   (dir_b),
    .mode      (mode_b),
    .ready     (ready_b),
    .tx        (tx_b),
    .busy      (busy_b),
    .frame_cnt (cnt_b)
  );

  // Command set plus the full 13-bit line sequence, first bit (start) in [12].
  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  speed;
    logic [3:0]  dir;
    logic [12:0] bits;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Runs one frame on instance a and checks it cycle by cycle.
  //   keep    : leave valid high with the same data so a second frame chains
  //   chained : this frame was accepted at the last edge of the previous call
  task automatic frame_a(input vec_t v, input bit keep, input bit chained);
    int c0;
    c0 = chained ? 1 : 0;
    if (!chained) begin
      check("ready_before_send", ready_a, 1);
      mode_a  = v.mode;
      speed_a = v.speed;
      dir_a   = v.dir;
      valid_a = 1'b1;
      @(posedge clk);
    end
    for (int c = c0; c <= 60; c++) begin
      @(negedge clk);
      if (!keep) begin
        // After accept: drop valid and change inputs; later offer a new
        // command while busy. None of this may alter the frame on the line.
        if (c == c0) begin
          valid_a = 1'b0;
          mode_a  = ~v.mode;
          speed_a = ~v.speed;
          dir_a   = ~v.dir;
        end
        if (c == 20) begin
          valid_a = 1'b1;
          mode_a  = 2'b11;
          speed_a = 4'h9;
          dir_a   = 4'h6;
        end
        if (c == 30) valid_a = 1'b0;
      end
      if (c < 52 && (c % 4) == 2)
        check($sformatf("tx_bit%0d", c / 4), tx_a, v.bits[12 - c / 4]);
      if (c == 1)  check("ready_busy_in_frame", {ready_a, busy_a}, 2'b01);
      if (c == 51) check("cnt_before_stop_end", cnt_a, exp_cnt_a[7:0]);
      if (c == 52) begin
        check("cnt_after_stop_end", cnt_a, 8'(exp_cnt_a + 1));
        check("tx_gap", tx_a, 1);
      end
      if (c == 59) check("ready_last_gap_cycle", ready_a, 0);
      if (c == 60) begin
        if (keep) check("chained_start", {ready_a, tx_a}, 2'b00);
        else      check("ready_busy_tx_idle", {ready_a, busy_a, tx_a}, 3'b101);
      end
    end
    exp_cnt_a++;
  endtask

  initial begin
    int prev_tx, last_start, starts;

    vecs[0] = '{2'b01, 4'h5, 4'h8, 13'b0010101100001};
    vecs[1] = '{2'b00, 4'h1, 4'h0, 13'b0000001000011};
    vecs[2] = '{2'b11, 4'hF, 4'hF, 13'b0111111111101};
    vecs[3] = '{2'b10, 4'hA, 4'h3, 13'b0101010001111};
    vecs[4] = '{2'b00, 4'h0, 4'h0, 13'b0000000000001};

    rst_a = 1'b0; rst_b = 1'b0;
    valid_a = 1'b0; mode_a = '0; speed_a = '0; dir_a = '0;
    valid_b = 1'b0; mode_b = '0; speed_b = '0; dir_b = '0;

    // Reset and idle.
    repeat (3) @(negedge clk);
    check("in_reset_a", {tx_a, ready_a, busy_a, cnt_a}, {1'b1, 1'b1, 1'b0, 8'h00});
    check("in_reset_b", {tx_b, ready_b, busy_b, cnt_b}, {1'b1, 1'b1, 1'b0, 8'h00});
    rst_a = 1'b1; rst_b = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check($sformatf("idle_a_%0d", i), {tx_a, ready_a, busy_a, cnt_a}, {1'b1, 1'b1, 1'b0, 8'h00});
      check($sformatf("idle_b_%0d", i), {tx_b, ready_b, busy_b, cnt_b}, {1'b1, 1'b1, 1'b0, 8'h00});
    end

    // Table of frames: bits, parity, timing, ignore-while-busy, input latching.
    @(negedge clk);
    for (int i = 0; i < 5; i++) frame_a(vecs[i], 1'b0, 1'b0);

    // valid held high through the end of the gap: next frame starts exactly at
    // edge 60 with the same data, then stops when valid is dropped.
    frame_a(vecs[0], 1'b1, 1'b0);
    frame_a(vecs[0], 1'b0, 1'b1);

    // Reset during a DATA bit (bit 2 of vecs[3] is a 0 on the line).
    check("ready_before_rst_frame", ready_a, 1);
    mode_a = vecs[3].mode; speed_a = vecs[3].speed; dir_a = vecs[3].dir;
    valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0;
    repeat (9) @(negedge clk);
    check("tx_low_before_rst", tx_a, 0);
    #1 rst_a = 1'b0;
    #1;
    check("tx_async_on_rst", tx_a, 1);
    check("ready_busy_on_rst", {ready_a, busy_a}, 2'b10);
    check("cnt_on_rst", cnt_a, 0);
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    exp_cnt_a = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check($sformatf("no_resume_%0d", i), {tx_a, ready_a, busy_a, cnt_a}, {1'b1, 1'b1, 1'b0, 8'h00});
    end
    frame_a(vecs[3], 1'b0, 1'b0);

    // Back-to-back frames on instance b with an all-zero command, so the only
    // 1->0 transition on the line is stop bit -> next start bit.
    @(negedge clk);
    valid_b = 1'b1;
    @(posedge clk);
    prev_tx = 1; last_start = 0; starts = 0;
    for (int c = 0; c <= 3328; c++) begin
      @(negedge clk);
      if (tx_b == 1'b0 && prev_tx == 1) begin
        if (starts > 0) check($sformatf("b2b_period_%0d", starts), c - last_start, 13);
        last_start = c;
        starts++;
      end
      prev_tx = int'(tx_b);
      if (c < 13) check($sformatf("b_bit%0d", c), tx_b, (c == 12) ? 1 : 0);
      if (c == 12) check("b_cnt_before_first", cnt_b, 0);
      if (c == 13) check("b_cnt_after_first", cnt_b, 1);
      if (c == 3327) begin
        check("b_cnt_255", cnt_b, 255);
        valid_b = 1'b0;
      end
      if (c == 3328) check("b_wrap_idle", {cnt_b, ready_b, tx_b}, {8'h00, 1'b1, 1'b1});
    end
    check("b_frame_starts", starts, 256);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cmd_frame_tx.md
# cmd_frame_tx

Serial command-frame transmitter for the controller-side end of the link that feeds the DTMR core's received `speed_cmd_i`, `dir_cmd_i` and `mode` inputs. It accepts one command set (mode, speed, direction) through a valid/ready handshake and serializes it onto a single idle-high line as a framed word:

- start bit
- payload
- even parity
- stop bit
- configurable inter-frame gap

The receiving end uses the parity bit to derive its error rate.

## Interface

Parameters:
- `cmd_l`, 4: width of speed and direction commands.
- `bit_div`, 8: clock cycles per line bit; must be ≥ 1.
- `gap_bits`, 2: idle (high) bit-times after each stop bit before `ready` reasserts; 0 allowed.

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `valid` input 1: command set present on `speed_cmd`, `dir_cmd`, `mode`.
- `speed_cmd` input `cmd_l`: speed command to send.
- `dir_cmd` input `cmd_l`: direction command to send.
- `mode` input 2: operation mode to send.
- `ready` output 1: block can accept a frame this cycle.
- `tx` output 1: serial line, idle high.
- `busy` output 1: frame or gap in progress (equals `~ready`).
- `frame_cnt` output 8: count of completed frames, wraps.

## Operation

- Accept: on a rising edge with `valid && ready`, the block latches `{mode, speed_cmd, dir_cmd}` into the shift register and computes the parity bit. Input changes after acceptance are ignored.
- `valid` while `ready` = 0 is ignored. There is no queue.
- Frame order on `tx` is fixed, `F = 2*cmd_l + 5` bits total (13 for `cmd_l` = 4):
  1. start bit = 0
  2. `mode[1]`, `mode[0]`
  3. `speed_cmd` MSB first
  4. `dir_cmd` MSB first
  5. parity
  6. stop bit = 1
- Parity is even over the `2*cmd_l + 2` payload bits: parity = XOR of all payload bits.
- Each bit is held for exactly `bit_div` cycles, timed by a bit-timer that counts 0..`bit_div`-1. A bit counter tracks position within the frame.
- FSM states:
  - IDLE: `tx` = 1, `ready` = 1. Goes to START on accept.
  - START: `tx` = 0 for one bit-time, then DATA.
  - DATA: shifts out `2*cmd_l + 2` payload bits, then PARITY.
  - PARITY: one bit-time, then STOP.
  - STOP: `tx` = 1 for one bit-time. At its end, `frame_cnt` increments; the FSM goes to GAP, or to IDLE if `gap_bits` = 0.
  - GAP: `tx` = 1 for `gap_bits` bit-times, then IDLE.
- `frame_cnt` wraps from 255 to 0. It increments only on a completed stop bit; aborted frames are not counted.
- Reset values (asserted asynchronously, held while `rst` = 0):
  - FSM = IDLE
  - `tx` = 1
  - `ready` = 1
  - `busy` = 0
  - `frame_cnt` = 0
  - timers and shift register = 0
- Reset mid-frame: `tx` returns high immediately (asynchronously). The frame is discarded and is not resumed after reset releases.

## Timing

- Define the accept edge as edge 0.
- `tx` is registered. It falls at edge 0; `ready` falls at the same edge.
- Start bit occupies cycles 0..`bit_div`-1 after edge 0. Frame bit k occupies cycles `k*bit_div`..`(k+1)*bit_div`-1.
- `frame_cnt` updates at edge `F*bit_div`.
- `ready` rises at edge `(F + gap_bits)*bit_div`.
- A new accept is legal in the first cycle `ready` = 1. Back-to-back frames therefore have a period of `(F + gap_bits)*bit_div` cycles, with no extra idle cycle.
- With `bit_div` = 1, each bit lasts exactly one cycle.

## Test plan

- Reset and idle: hold `rst` low, then release; no `valid`. Required: `tx` = 1, `ready` = 1, `busy` = 0, `frame_cnt` = 0 for 100 cycles.
- Basic frame (`cmd_l` = 4, `bit_div` = 4, `gap_bits` = 2): send mode = 01, speed = 5, dir = 8.
  - `tx` bit sequence: 0, 01, 0101, 1000, parity 0, stop 1.
  - Each bit lasts 4 cycles.
  - `frame_cnt` = 1 at cycle 52.
  - `ready` returns at cycle 60.
- Odd parity payload: send mode = 00, speed = 1, dir = 0. Required: parity bit = 1, sampled at cycles 44..47.
- Ignore and latch: assert `valid` with new values during a frame, and change inputs after accept. Required: the transmitted frame is unchanged, and no second frame is sent unless `valid` is still high once `ready` = 1.
- Back-to-back wrap: hold `valid` high for 256 frames (`bit_div` = 1, `gap_bits` = 0). Required:
  - consecutive frames are exactly 13 cycles apart;
  - `frame_cnt` reads 0 after the 256th frame.
- Reset mid-frame: assert `rst` low during a DATA bit. Required:
  - `tx` = 1 immediately, before the next edge;
  - after release, `ready` = 1 and `frame_cnt` is unchanged at 0;
  - the next accepted frame is transmitted correctly from its start bit.
